qeciphy_traffic_gen_chk: RTL and testbench
==========================================

# qeciphy_traffic_gen_chk

Parametrised AXI-Stream traffic generator and self-synchronising checker for QECIPHY link bring-up and soak testing on the example designs. It drives the PHY TX stream with a selectable pattern (incrementing counter, PRBS-31, walking-one) and checks the PHY RX stream against the same pattern. It also reports lock, a sticky error flag, a saturating error count and a received-word count. It replaces ad-hoc counter/compare logic in the top-level wrappers and can be pointed at a loopback or a remote link partner running the same mode.

## Interface
- DATA_W, 64: stream width in bits; 32..128, multiple of 8 (PRBS mode needs ≥31).
- ERR_CNT_W, 16: error counter width.
- WORD_CNT_W, 32: received-word counter width.
- LOCK_CNT, 4: consecutive matching words required to declare lock; 1..15.

- ACLK  input  1  stream and control clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  run generator and checker.
- mode  input  2  0 counter, 1 PRBS-31, 2 walking-one, 3 treated as counter.
- clear  input  1  synchronous single-cycle clear of status and counters.
- tx_tdata  output  DATA_W  generated word.
- tx_tvalid  output  1  generated word valid.
- tx_tready  input  1  PHY accepts word.
- rx_tdata  input  DATA_W  received word.
- rx_tvalid  input  1  received word valid.
- rx_tready  output  1  tied 1 (PHY RX has no backpressure).
- locked  output  1  checker synchronised to the incoming pattern.
- err_sticky  output  1  at least one mismatch since reset or clear while locked.
- err_count  output  ERR_CNT_W  mismatches while locked; saturates at all-ones.
- word_count  output  WORD_CNT_W  received words while enabled; wraps.

## Operation
- Next-word function f(w), shared by generator and checker:
  - Counter: f(w) = w+1 mod 2^DATA_W.
  - Walking-one: f(w) = rotate-left(w, 1); w==0 maps to 1.
  - PRBS-31 (x^31+x^28+1): state s = w[30:0]. Run DATA_W serial steps, each b = s[30]^s[27], s = {s[29:0], b]. The first generated bit lands at MSB and the last at bit 0.
- Seed word: counter 0, walking-one 1, PRBS all-ones.
- Mode latch: mode is captured into an internal register on the enable rising edge. Changes to mode while enable=1 are ignored.
- Generator: on the enable rising edge, tx_tdata is loaded with the seed of the latched mode and tx_tvalid is set the next cycle.
  - On tx_tvalid && tx_tready, tx_tdata advances to f(tx_tdata).
  - tx_tdata is held stable while tx_tvalid=1 and tx_tready=0.
  - On enable fall, tx_tvalid stays 1 until the pending word is accepted, then drops to 0. tx_tvalid never drops before a handshake.
- Checker FSM, states IDLE, HUNT, LOCKED. A word counts only on rx_tvalid=1 while enable=1.
  - IDLE: entered on reset, on enable=0 and on clear; moves to HUNT when enable=1.
  - HUNT: the first word seeds ref = f(rx_tdata) with match counter = 0.
  - HUNT, later words: a match increments the match counter and advances ref = f(ref). A mismatch reseeds ref = f(rx_tdata) and zeroes the match counter. Move to LOCKED when the match counter reaches LOCK_CNT.
  - HUNT never increments err_count.
  - LOCKED: locked=1. A mismatch increments err_count (saturating) and sets err_sticky. ref always advances ref = f(ref), never reseeds, so an isolated bit error costs exactly one count.
- word_count increments on every rx_tvalid while enable=1, in any checker state.
- clear: zeroes err_count, word_count, err_sticky and locked, and returns the FSM to IDLE. clear wins over a simultaneous error or increment. clear does not affect the generator.

## Timing
- Reset values: tx_tvalid 0, tx_tdata 0, locked 0, err_sticky 0, err_count 0, word_count 0. rx_tready is 1 at all times, including during reset.
- Latency:
  - enable rising at edge N: tx_tvalid=1 and tx_tdata=seed after edge N+1.
  - rx word at edge N: word_count, err_count and err_sticky are updated after edge N.
  - locked asserts after the edge that samples the LOCK_CNT-th consecutive match.
- The f(w) evaluation is single-cycle combinational; back-to-back words (tvalid held high) are supported at full rate on both TX and RX.
- Asynchronous reset mid-stream: all state returns to reset values immediately. Operation restarts from the seed on the next enable rising edge; while enable is held high, that edge occurs at the first edge after rst_n release.

## Test plan
- Counter mode, TX looped to RX, tready=1, 1000 cycles:
  - tx_tdata is 0,1,2,…
  - locked=1 after the 5th received word (LOCK_CNT=4).
  - err_count=0; word_count equals the number of received words.
- PRBS mode, DATA_W=64, loopback:
  - The first two tx words are all-ones, then f(all-ones) computed by the serial-step model.
  - Flipping bit 17 of one rx word while LOCKED gives err_count=1 and err_sticky=1, and locked stays 1.
- Backpressure, random tready at 50%:
  - tx_tdata is stable while tx_tready=0.
  - The sequence has no gaps or repeats.
  - Deasserting enable while a word is pending holds tvalid until its handshake.
- Self-sync:
  - Start RX mid-sequence at counter value 0x1234: locked after LOCK_CNT+1 words, err_count=0.
  - Inject a mismatch during HUNT: the checker reseeds and err_count stays 0.
- Saturation and clear, ERR_CNT_W=4:
  - 20 locked errors give err_count=15.
  - clear asserted together with an error leaves all counters 0 and locked=0.
  - The checker relocks afterwards.
- Reset and mode:
  - Change mode while enabled: the pattern is unchanged.
  - Toggle enable with mode=2: tx restarts at 1,2,4,…
  - Asserting rst_n low mid-stream forces all outputs to their reset values within the same cycle.

Source files
------------

// File: rtl/qeciphy_traffic_gen_chk.sv
// rtl/qeciphy_traffic_gen_chk.sv - AXI-Stream pattern generator and self-synchronising checker
module qeciphy_traffic_gen_chk #(
    parameter int DATA_W     = 64,
    parameter int ERR_CNT_W  = 16,
    parameter int WORD_CNT_W = 32,
    parameter int LOCK_CNT   = 4
) (
    input  logic                  ACLK,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  clear,
    output logic [DATA_W-1:0]     tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    input  logic [DATA_W-1:0]     rx_tdata,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    output logic                  locked,
    output logic                  err_sticky,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WORD_CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    // PRBS-31 (x^31 + x^28 + 1): DATA_W serial steps from the low 31 bits,
    // first generated bit ends up at the MSB.
    function automatic logic [DATA_W-1:0] prbs_next(input logic [DATA_W-1:0] w);
        logic [30:0]       s;
        logic              b;
        logic [DATA_W-1:0] r;
        s = w[30:0];
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            b = s[30] ^ s[27];
            s = {s[29:0], b};
            r[DATA_W-1-i] = b;
        end
        return r;
    endfunction

    // Next-word function shared by generator and checker.
    function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m,
                                                    input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        case (m)
            2'd1:    r = prbs_next(w);
            2'd2:    r = (w == '0) ? DATA_W'(1) : {w[DATA_W-2:0], w[DATA_W-1]};
            default: r = w + DATA_W'(1);
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] seed_word(input logic [1:0] m);
        logic [DATA_W-1:0] r;
        case (m)
            2'd1:    r = {DATA_W{1'b1}};
            2'd2:    r = DATA_W'(1);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic              enable_q;
    logic              en_rise;
    logic [1:0]        mode_lat;
    logic              start_pend;

    chk_state_t        state, state_nxt;
    logic [DATA_W-1:0] ref_word, ref_nxt;
    logic              have_ref, have_ref_nxt;
    logic [3:0]        match_cnt, match_nxt;
    logic              mismatch_err;
    logic              rx_word;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] ref_adv;

    assign rx_tready = 1'b1;
    assign en_rise   = enable && !enable_q;
    assign rx_word   = rx_tvalid && enable;
    assign rx_next   = next_word(mode_lat, rx_tdata);
    assign ref_adv   = next_word(mode_lat, ref_word);
    assign locked    = (state == ST_LOCKED);

    // Generator: seed on enable rise, raise tvalid a cycle later, advance on
    // each handshake, and only drop tvalid after the last pending handshake.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= 1'b0;
            mode_lat   <= 2'd0;
            start_pend <= 1'b0;
            tx_tdata   <= '0;
            tx_tvalid  <= 1'b0;
        end else begin
            enable_q <= enable;
            if (en_rise) begin
                mode_lat   <= mode;
                tx_tdata   <= seed_word(mode);
                start_pend <= 1'b1;
            end else begin
                start_pend <= 1'b0;
                if (start_pend && enable) begin
                    tx_tvalid <= 1'b1;
                end else if (tx_tvalid && tx_tready) begin
                    tx_tdata <= next_word(mode_lat, tx_tdata);
                    if (!enable) begin
                        tx_tvalid <= 1'b0;
                    end
                end
            end
        end
    end

    // Checker next state: hunt reseeds on mismatch, locked only ever advances
    // the reference so a single corrupted word costs exactly one error.
    always_comb begin
        state_nxt    = state;
        ref_nxt      = ref_word;
        have_ref_nxt = have_ref;
        match_nxt    = match_cnt;
        mismatch_err = 1'b0;
        case (state)
            ST_IDLE: begin
                have_ref_nxt = 1'b0;
                match_nxt    = 4'd0;
                if (enable) begin
                    state_nxt = ST_HUNT;
                    if (rx_word) begin
                        ref_nxt      = rx_next;
                        have_ref_nxt = 1'b1;
                    end
                end
            end
            ST_HUNT: begin
                if (rx_word) begin
                    if (!have_ref) begin
                        ref_nxt      = rx_next;
                        have_ref_nxt = 1'b1;
                        match_nxt    = 4'd0;
                    end else if (rx_tdata == ref_word) begin
                        ref_nxt   = ref_adv;
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt == 4'(LOCK_CNT - 1)) begin
                            state_nxt = ST_LOCKED;
                            match_nxt = 4'd0;
                        end
                    end else begin
                        ref_nxt   = rx_next;
                        match_nxt = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (rx_word) begin
                    ref_nxt = ref_adv;
                    if (rx_tdata != ref_word) begin
                        mismatch_err = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (!enable || clear) begin
            state_nxt    = ST_IDLE;
            have_ref_nxt = 1'b0;
            match_nxt    = 4'd0;
        end
    end

    // Checker state register.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ref_word  <= '0;
            have_ref  <= 1'b0;
            match_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            ref_word  <= ref_nxt;
            have_ref  <= have_ref_nxt;
            match_cnt <= match_nxt;
        end
    end

    // Status counters; clear beats a simultaneous error or word.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
            word_count <= '0;
        end else if (clear) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
            word_count <= '0;
        end else begin
            if (mismatch_err) begin
                err_sticky <= 1'b1;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
            if (rx_word) begin
                word_count <= word_count + WORD_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_qeciphy_traffic_gen_chk.sv
// tb/tb_qeciphy_traffic_gen_chk.sv - bench for qeciphy_traffic_gen_chk
module tb_qeciphy_traffic_gen_chk;

    localparam int DW = 64;
    localparam int EW = 4;
    localparam int WW = 32;
    localparam int LC = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          ACLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          clear = 1'b0;
    logic [DW-1:0] tx_tdata;
    logic          tx_tvalid;
    logic          tx_tready = 1'b0;
    logic [DW-1:0] rx_tdata;
    logic          rx_tvalid;
    logic          rx_tready;
    logic          locked;
    logic          err_sticky;
    logic [EW-1:0] err_count;
    logic [WW-1:0] word_count;

    logic          loop = 1'b1;
    logic [DW-1:0] flip = '0;
    logic [DW-1:0] rx_d = '0;
    logic          rx_v = 1'b0;

    int total = 0;
    int bad = 0;

    qeciphy_traffic_gen_chk #(
        .DATA_W(DW), .ERR_CNT_W(EW), .WORD_CNT_W(WW), .LOCK_CNT(LC)
    ) dut (
        .ACLK(ACLK), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .locked(locked), .err_sticky(err_sticky), .err_count(err_count),
        .word_count(word_count)
    );

    always #5 ACLK = ~ACLK;

    always_comb begin
        rx_tdata  = loop ? (tx_tdata ^ flip) : rx_d;
        rx_tvalid = loop ? (tx_tvalid && tx_tready) : rx_v;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pattern rules written as a serial bit stream / plain arithmetic.
    function automatic logic [DW-1:0] m_next(input logic [1:0] md, input logic [DW-1:0] w);
        logic [30:0]   s;
        logic          b;
        logic [DW-1:0] r;
        if (md == 2'd1) begin
            s = w[30:0];
            r = '0;
            repeat (DW) begin
                b = s[30] ^ s[27];
                s = {s[29:0], b};
                r = {r[DW-2:0], b};
            end
            return r;
        end else if (md == 2'd2) begin
            if (w == 0) return 1;
            return (w << 1) | (w >> (DW - 1));
        end
        return w + 1;
    endfunction

    function automatic logic [DW-1:0] m_seed(input logic [1:0] md);
        if (md == 2'd1) return '1;
        if (md == 2'd2) return 1;
        return 0;
    endfunction

    // Reference model state.
    logic          m_en_q = 1'b0;
    logic [1:0]    m_mode = 2'd0;
    logic [DW-1:0] exp_tx = '0;
    logic          prev_pend = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          m_locked = 1'b0;
    int            m_err = 0;
    logic          m_sticky = 1'b0;
    int unsigned   m_words = 0;
    logic [DW-1:0] m_ref = '0;
    logic [DW-1:0] hist[$];

    initial forever begin
        @(posedge ACLK or negedge rst_n);
        if (!rst_n) begin
            m_en_q = 0; m_mode = 0; exp_tx = 0; prev_pend = 0;
            m_locked = 0; m_err = 0; m_sticky = 0; m_words = 0; m_ref = 0;
            hist.delete();
        end else begin
            if (prev_pend) begin
                chk("tx_hold_valid", tx_tvalid, 1);
                chk("tx_hold_data", tx_tdata, prev_data);
            end
            if (tx_tvalid && tx_tready) begin
                chk("tx_seq", tx_tdata, exp_tx);
                exp_tx = m_next(m_mode, exp_tx);
            end
            prev_pend = tx_tvalid && !tx_tready;
            prev_data = tx_tdata;
            if (clear) begin
                m_locked = 0; m_err = 0; m_sticky = 0; m_words = 0;
                hist.delete();
            end else if (!enable) begin
                m_locked = 0;
                hist.delete();
            end else if (rx_tvalid) begin
                m_words++;
                if (m_locked) begin
                    if (rx_tdata != m_ref) begin
                        m_sticky = 1;
                        if (m_err < ERR_MAX) m_err++;
                    end
                    m_ref = m_next(m_mode, m_ref);
                end else begin
                    if (hist.size() != 0 && rx_tdata != m_next(m_mode, hist[$]))
                        hist.delete();
                    hist.push_back(rx_tdata);
                    if (hist.size() == LC + 1) begin
                        m_locked = 1;
                        m_ref = m_next(m_mode, rx_tdata);
                        hist.delete();
                    end
                end
            end
            if (enable && !m_en_q) begin
                m_mode = mode;
                exp_tx = m_seed(mode);
            end
            m_en_q = enable;
        end
    end

    // Status outputs against the model every cycle.
    initial forever begin
        @(posedge ACLK);
        #1;
        chk("locked", locked, m_locked);
        chk("err_count", err_count, m_err);
        chk("err_sticky", err_sticky, m_sticky);
        chk("word_count", word_count, m_words);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic stop_gen();
        tx_tready = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 50 && tx_tvalid; i++) tick(1);
        chk("gen_stop", tx_tvalid, 0);
    endtask

    logic [DW-1:0] d, a, j, v, c;

    initial begin
        tick(2);
        chk("rst_tvalid", tx_tvalid, 0);
        chk("rst_tdata", tx_tdata, 0);
        chk("rst_rx_tready", rx_tready, 1);
        chk("rst_locked", locked, 0);
        chk("rst_words", word_count, 0);
        rst_n = 1'b1;
        tick(1);

        // counter loopback
        mode = 2'd0; tx_tready = 1'b1; enable = 1'b1;
        tick(1);
        chk("cnt_lat_v0", tx_tvalid, 0);
        tick(1);
        chk("cnt_first_v", tx_tvalid, 1);
        chk("cnt_first_d", tx_tdata, 0);
        tick(4);
        chk("cnt_words4", word_count, 4);
        chk("cnt_unlocked4", locked, 0);
        tick(1);
        chk("cnt_locked5", locked, 1);
        chk("cnt_tdata5", tx_tdata, 5);
        d = tx_tdata;
        mode = 2'd2;
        tick(1);
        chk("mode_ignored", tx_tdata, d + 1);
        for (int i = 0; i < 995; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            tick(1);
        end
        chk("cnt_err0", err_count, 0);
        chk("cnt_words", word_count, 1001);
        stop_gen();

        // walking one, restarted by an enable toggle
        for (int r = 0; r < 2; r++) begin
            tick(2);
            mode = 2'd2; enable = 1'b1;
            tick(2);
            chk("walk_1", tx_tdata, 1);
            tick(1);
            chk("walk_2", tx_tdata, 2);
            tick(1);
            chk("walk_4", tx_tdata, 4);
            stop_gen();
        end

        // PRBS with a single flipped bit while locked
        tick(2);
        mode = 2'd1; enable = 1'b1;
        tick(2);
        chk("prbs_seed", tx_tdata, '1);
        tick(1);
        chk("prbs_w1", tx_tdata, m_next(2'd1, '1));
        for (int i = 0; i < 20 && !locked; i++) tick(1);
        chk("prbs_locked", locked, 1);
        flip = 64'h1 << 17;
        tick(1);
        flip = '0;
        tick(5);
        chk("prbs_err1", err_count, 1);
        chk("prbs_sticky", err_sticky, 1);
        chk("prbs_still_locked", locked, 1);
        stop_gen();

        // random backpressure, random pattern
        tick(2);
        mode = 2'($urandom_range(0, 3)); enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tx_tready = 1'($urandom_range(0, 1));
            tick(1);
        end
        tx_tready = 1'b0;
        tick(1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("bp_pending_valid", tx_tvalid, 1);
        end
        tx_tready = 1'b1;
        tick(1);
        chk("bp_drop_valid", tx_tvalid, 0);

        // self-sync from mid-sequence
        loop = 1'b0;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_words", word_count, 0);
        mode = 2'd0; enable = 1'b1;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            rx_d = 64'h1234 + 64'(k); rx_v = 1'b1;
            tick(1);
            if (k == 3) chk("sync_unlocked", locked, 0);
        end
        rx_v = 1'b0;
        chk("sync_locked", locked, 1);
        chk("sync_err0", err_count, 0);

        // mismatch during hunt reseeds without counting an error
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
        a = 64'($urandom);
        j = a + 64'd1000;
        rx_v = 1'b1;
        rx_d = a; tick(1);
        rx_d = a + 1; tick(1);
        for (int k = 0; k < 5; k++) begin
            rx_d = j + 64'(k);
            tick(1);
            if (k == 3) chk("hunt_unlocked", locked, 0);
        end
        chk("hunt_locked", locked, 1);
        chk("hunt_err0", err_count, 0);

        // saturation, then clear colliding with an error
        v = j + 5;
        for (int k = 0; k < 20; k++) begin
            rx_d = v ^ 64'h1;
            v = v + 1;
            tick(1);
        end
        chk("sat_err", err_count, 15);
        chk("sat_sticky", err_sticky, 1);
        chk("sat_locked", locked, 1);
        rx_d = v ^ 64'h1; clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_err", err_count, 0);
        chk("clr_words2", word_count, 0);
        chk("clr_locked", locked, 0);
        chk("clr_sticky", err_sticky, 0);
        c = 64'($urandom);
        for (int k = 0; k < 5; k++) begin
            rx_d = c + 64'(k);
            tick(1);
        end
        rx_v = 1'b0;
        chk("relock", locked, 1);
        enable = 1'b0;
        tick(2);

        // asynchronous reset mid-stream
        loop = 1'b1; mode = 2'd0; tx_tready = 1'b1; enable = 1'b1;
        tick(20);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", tx_tvalid, 0);
        chk("arst_tdata", tx_tdata, 0);
        chk("arst_locked", locked, 0);
        chk("arst_words", word_count, 0);
        chk("arst_err", err_count, 0);
        chk("arst_sticky", err_sticky, 0);
        chk("arst_rx_tready", rx_tready, 1);
        @(negedge ACLK);
        rst_n = 1'b1;
        tick(1);
        chk("arst_restart_v0", tx_tvalid, 0);
        tick(1);
        chk("arst_restart_v", tx_tvalid, 1);
        chk("arst_restart_d", tx_tdata, 0);
        tick(3);
        chk("arst_restart_d3", tx_tdata, 3);
        stop_gen();
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
